// File: rtl/eth_tm_report_pkg.sv
// Shared Ethernet ring/pipe types, packet ids and the TM report FSM state types.
package eth_tm_report_pkg;

  localparam int TMO_W   = 16;
  localparam int RETRY_W = 8;

  localparam logic [7:0] TMPID           = 8'h5A;
  localparam logic [7:0] rptPacketType   = 8'h21;
  localparam logic [7:0] ackPacketType   = 8'h22;
  localparam logic [7:0] nackPacketType  = 8'h23;

  typedef enum logic [1:0] {rx_none, rx_start, rx_data, rx_end} eth_rx_stype_type;
  typedef enum logic [2:0] {tx_none, tx_start_empty, tx_start, tx_data, tx_end} eth_tx_stype_type;

  // Header fields are meaningful on start beats, data on data/end beats.
  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  ptype;
    logic [15:0] seqnum;
    logic [31:0] data;
  } eth_msg_type;

  typedef struct packed {
    eth_rx_stype_type stype;
    eth_msg_type      msg;
  } eth_rx_pipe_data_type;

  typedef struct packed {
    eth_tx_stype_type stype;
    eth_msg_type      msg;
  } eth_tx_ring_data_type;

  typedef enum logic [2:0] {
    rp_idle, rp_wait_token, rp_send_data, rp_wait_ack, rp_check_ack
  } eth_tm_report_state_type;

  typedef struct packed {
    eth_tm_report_state_type st;
    logic [15:0]             seqnum;
    logic [15:0]             tmpseq;
    logic [RETRY_W-1:0]      retry;
    logic [TMO_W-1:0]        tmo;
    logic [31:0]             payload;
    logic                    is_ack;
    logic                    busy;
    logic                    done;
    logic                    err;
    eth_tx_ring_data_type    tx_out;
    eth_rx_pipe_data_type    rx_out;
  } eth_tm_report_reg_type;

  function automatic logic [15:0] ldsts_big_endian(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

endpackage

// File: rtl/eth_tm_report.sv
// Sends one TM report on the tx ring and waits for a matching ack; retransmits on
// nack, bad CRC or timeout, and gives up after MAX_RETRY retransmissions.
module eth_tm_report
  import eth_tm_report_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRY      = 7,
  parameter logic [7:0] RPT_PID        = TMPID
) (
  input  logic                 clk,
  input  logic                 reset,
  input  eth_rx_pipe_data_type rx_pipe_in,
  output eth_rx_pipe_data_type rx_pipe_out,
  input  eth_tx_ring_data_type tx_ring_in,
  output eth_tx_ring_data_type tx_ring_out,
  input  logic                 rpt_req,
  input  logic [31:0]          rpt_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  eth_tm_report_reg_type r_q, r_d;
  logic ack_hit, timed_out, retry_now;

  always_comb begin
    r_d           = r_q;
    r_d.done      = 1'b0;
    r_d.err       = 1'b0;
    r_d.rx_out    = rx_pipe_in;
    r_d.tx_out    = tx_ring_in;
    retry_now     = 1'b0;
    timed_out     = (r_q.tmo >= TMO_LAST);
    ack_hit       = (rx_pipe_in.stype == rx_start) &&
                    (rx_pipe_in.msg.pid == RPT_PID) &&
                    ((rx_pipe_in.msg.ptype == ackPacketType) ||
                     (rx_pipe_in.msg.ptype == nackPacketType)) &&
                    (ldsts_big_endian(rx_pipe_in.msg.seqnum) == r_q.tmpseq);

    // Timeout counter saturates so a stalled link never wraps back below the limit.
    if ((r_q.st == rp_wait_ack || r_q.st == rp_check_ack) && r_q.tmo != '1)
      r_d.tmo = r_q.tmo + 1'b1;

    unique case (r_q.st)
      rp_idle: begin
        if (rpt_req) begin
          r_d.payload = rpt_data;
          r_d.tmpseq  = r_q.seqnum + 16'd1;
          r_d.retry   = '0;
          r_d.busy    = 1'b1;
          r_d.st      = rp_wait_token;
        end
      end
      rp_wait_token: begin
        if (tx_ring_in.stype == tx_start_empty) begin
          r_d.tx_out            = '0;
          r_d.tx_out.stype      = tx_start;
          r_d.tx_out.msg.pid    = RPT_PID;
          r_d.tx_out.msg.ptype  = rptPacketType;
          r_d.tx_out.msg.seqnum = ldsts_big_endian(r_q.tmpseq);
          r_d.st                = rp_send_data;
        end
      end
      rp_send_data: begin
        r_d.tx_out          = '0;
        r_d.tx_out.stype    = tx_data;
        r_d.tx_out.msg.data = r_q.payload;
        r_d.tmo             = '0;
        r_d.st              = rp_wait_ack;
        // Anything arriving in the slot we own means the ring is corrupt.
        if (tx_ring_in.stype != tx_none) begin
          r_d.err   = 1'b1;
          retry_now = 1'b1;
        end
      end
      rp_wait_ack: begin
        if (ack_hit) begin
          r_d.is_ack = (rx_pipe_in.msg.ptype == ackPacketType);
          r_d.st     = rp_check_ack;
        end else if (timed_out) begin
          retry_now = 1'b1;
        end
      end
      rp_check_ack: begin
        if (rx_pipe_in.stype == rx_end) begin
          if (!rx_pipe_in.msg.data[0] && r_q.is_ack) begin
            r_d.seqnum = r_q.tmpseq;
            r_d.done   = 1'b1;
            r_d.busy   = 1'b0;
            r_d.st     = rp_idle;
          end else begin
            retry_now = 1'b1;
          end
        end else if (timed_out) begin
          retry_now = 1'b1;
        end
      end
      default: r_d.st = rp_idle;
    endcase

    if (retry_now) begin
      r_d.retry = r_q.retry + 1'b1;
      if (r_q.retry < RETRY_LIM) begin
        r_d.st = rp_wait_token;
      end else begin
        r_d.err  = 1'b1;
        r_d.busy = 1'b0;
        r_d.st   = rp_idle;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= '0;
    else       r_q <= r_d;
  end

  assign rx_pipe_out = r_q.rx_out;
  assign tx_ring_out = r_q.tx_out;
  assign busy        = r_q.busy;
  assign done        = r_q.done;
  assign err         = r_q.err;

endmodule

// File: tb/tb_eth_tm_report.sv
// Directed bench for eth_tm_report: a cycle table for the good-ack path plus
// hand-written sequences for nack, bad CRC, timeout, ring violation, seq wrap and reset.
module tb_eth_tm_report;
  import eth_tm_report_pkg::*;

  localparam int TMO  = 16;
  localparam int MAXR = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  eth_rx_pipe_data_type rx_in, rx_pipe_out;
  eth_tx_ring_data_type tx_in, tx_ring_out;
  logic                 req;
  logic [31:0]          data;
  logic                 busy, done, err;

  int checks   = 0;
  int failures = 0;

  eth_tm_report #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .rx_pipe_in(rx_in), .rx_pipe_out(rx_pipe_out),
    .tx_ring_in(tx_in), .tx_ring_out(tx_ring_out),
    .rpt_req(req), .rpt_data(data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic                 req;
    logic [31:0]          data;
    eth_tx_ring_data_type tx;
    eth_rx_pipe_data_type rx;
    eth_tx_stype_type     ex_st;
    logic [31:0]          ex_key;
    logic                 ex_busy;
    logic                 ex_done;
    logic                 ex_err;
  } vec_t;

  vec_t tbl[7];

  function automatic eth_tx_ring_data_type mk_tx(input eth_tx_stype_type s, input logic [31:0] d);
    eth_tx_ring_data_type t;
    t          = '0;
    t.stype    = s;
    t.msg.data = d;
    return t;
  endfunction

  function automatic eth_rx_pipe_data_type mk_rx(input eth_rx_stype_type s, input logic [7:0] pid,
                                                 input logic [7:0] pt, input logic [15:0] seq,
                                                 input logic [31:0] d);
    eth_rx_pipe_data_type r;
    r            = '0;
    r.stype      = s;
    r.msg.pid    = pid;
    r.msg.ptype  = pt;
    r.msg.seqnum = seq;
    r.msg.data   = d;
    return r;
  endfunction

  // Start beats are identified by their header, other beats by their data word.
  function automatic logic [31:0] tx_key(input eth_tx_ring_data_type t);
    if (t.stype == tx_start) return {t.msg.pid, t.msg.ptype, t.msg.seqnum};
    return t.msg.data;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req   = 1'b0;
    data  = 32'd0;
    tx_in = mk_tx(tx_none, 32'd0);
    rx_in = mk_rx(rx_none, 8'd0, 8'd0, 16'd0, 32'd0);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  // Request a report, hand it a token, and check the start and data beats.
  task automatic send_report(input string tag, input logic [31:0] d, input logic [15:0] wire_seq);
    req  = 1'b1;
    data = d;
    cyc();
    req   = 1'b0;
    tx_in = mk_tx(tx_start_empty, 32'd0);
    cyc();
    chk({tag, "_start"}, tx_key(tx_ring_out), {TMPID, rptPacketType, wire_seq});
    tx_in = mk_tx(tx_none, 32'd0);
    cyc();
    chk({tag, "_data"}, tx_key(tx_ring_out), d);
  endtask

  task automatic send_ack(input logic [7:0] pid, input logic [7:0] pt, input logic [15:0] wire_seq,
                          input logic crc_bad);
    rx_in = mk_rx(rx_start, pid, pt, wire_seq, 32'd0);
    cyc();
    rx_in = mk_rx(rx_end, 8'd0, 8'd0, 16'd0, {31'd0, crc_bad});
    cyc();
    rx_in = mk_rx(rx_none, 8'd0, 8'd0, 16'd0, 32'd0);
  endtask

  // Offer tokens until the DUT claims one; the slot after a claim is left empty.
  task automatic run_tokens(input int bound, output int n, output int dones);
    n     = 0;
    dones = 0;
    for (int i = 0; i < bound; i++) begin
      tx_in = mk_tx(tx_start_empty, 32'd0);
      cyc();
      n++;
      if (done) dones++;
      if (tx_ring_out.stype == tx_start) break;
    end
    tx_in = mk_tx(tx_none, 32'd0);
  endtask

  eth_tm_report_reg_type frc;
  int n, dones, starts, errs, err_t, badseq;
  int ts[4];

  initial begin
    // Reset with busy inputs: outputs must still be idle.
    reset = 1'b1;
    req   = 1'b1;
    data  = 32'hFFFF_FFFF;
    tx_in = mk_tx(tx_start_empty, 32'h1);
    rx_in = mk_rx(rx_start, TMPID, ackPacketType, 16'h0100, 32'h0);
    cyc();
    chk("rst_tx_st", 32'(tx_ring_out.stype), 32'(tx_none));
    chk("rst_rx_st", 32'(rx_pipe_out.stype), 32'(rx_none));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle_in();
    cyc();
    reset = 1'b0;
    cyc();

    // Good ack: each row's outputs are those registered at the edge after its inputs.
    tbl[0] = '{1'b1, 32'hCAFEF00D, mk_tx(tx_none, 0), mk_rx(rx_none, 0, 0, 0, 0),
               tx_none, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0, mk_tx(tx_data, 32'h12345678), mk_rx(rx_data, 0, 0, 0, 32'h77),
               tx_data, 32'h12345678, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0, mk_tx(tx_start_empty, 0), mk_rx(rx_none, 0, 0, 0, 0),
               tx_start, 32'h5A210100, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0, mk_tx(tx_none, 0), mk_rx(rx_none, 0, 0, 0, 0),
               tx_data, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0, mk_tx(tx_none, 0), mk_rx(rx_start, 8'h5A, 8'h22, 16'h0100, 0),
               tx_none, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0, mk_tx(tx_none, 0), mk_rx(rx_end, 0, 0, 0, 0),
               tx_none, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'h0, mk_tx(tx_none, 0), mk_rx(rx_none, 0, 0, 0, 0),
               tx_none, 32'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      req   = tbl[i].req;
      data  = tbl[i].data;
      tx_in = tbl[i].tx;
      rx_in = tbl[i].rx;
      cyc();
      chk($sformatf("vec%0d_tx_st", i), 32'(tx_ring_out.stype), 32'(tbl[i].ex_st));
      chk($sformatf("vec%0d_tx_key", i), tx_key(tx_ring_out), tbl[i].ex_key);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].ex_busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].ex_done));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].ex_err));
      chk($sformatf("vec%0d_rx_st", i), 32'(rx_pipe_out.stype), 32'(tbl[i].rx.stype));
      chk($sformatf("vec%0d_rx_dat", i), rx_pipe_out.msg.data, tbl[i].rx.msg.data);
    end
    idle_in();

    // Nack then ack: retransmission reuses seq and payload.
    do_reset();
    send_report("nk1", 32'h11112222, 16'h0100);
    send_ack(TMPID, nackPacketType, 16'h0100, 1'b0);
    chk("nk_done0", 32'(done), 32'd0);
    chk("nk_busy1", 32'(busy), 32'd1);
    run_tokens(8, n, dones);
    chk("nk2_start", tx_key(tx_ring_out), 32'h5A210100);
    cyc();
    chk("nk2_data", tx_key(tx_ring_out), 32'h11112222);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b0);
    chk("nk_done1", 32'(done), 32'd1);
    chk("nk_busy0", 32'(busy), 32'd0);
    send_report("nk_next", 32'hA5A5A5A5, 16'h0200);
    send_ack(TMPID, ackPacketType, 16'h0200, 1'b0);
    chk("nk_next_done", 32'(done), 32'd1);

    // Bad CRC forces a retransmit; wrong seq / wrong pid acks are ignored until timeout.
    do_reset();
    send_report("crc1", 32'h0BADC0DE, 16'h0100);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b1);
    chk("crc_done0", 32'(done), 32'd0);
    chk("crc_busy1", 32'(busy), 32'd1);
    run_tokens(8, n, dones);
    chk("crc2_start", tx_key(tx_ring_out), 32'h5A210100);
    cyc();
    chk("crc2_data", tx_key(tx_ring_out), 32'h0BADC0DE);
    send_ack(TMPID, ackPacketType, 16'h0200, 1'b0);
    chk("wseq_done0", 32'(done), 32'd0);
    send_ack(8'h33, ackPacketType, 16'h0100, 1'b0);
    chk("wpid_done0", 32'(done), 32'd0);
    run_tokens(40, n, dones);
    chk("crc3_start_st", 32'(tx_ring_out.stype), 32'(tx_start));
    chk("crc3_no_done", 32'(dones), 32'd0);
    chk("crc3_gap_ge16", 32'((n + 4) >= TMO), 32'd1);
    cyc();
    chk("crc3_data", tx_key(tx_ring_out), 32'h0BADC0DE);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b0);
    chk("crc3_done", 32'(done), 32'd1);

    // Ring violation while sending the data beat.
    do_reset();
    req  = 1'b1;
    data = 32'h600D0001;
    cyc();
    req   = 1'b0;
    tx_in = mk_tx(tx_start_empty, 32'd0);
    cyc();
    tx_in = mk_tx(tx_data, 32'hDEAD);
    cyc();
    chk("viol_err", 32'(err), 32'd1);
    chk("viol_busy", 32'(busy), 32'd1);
    chk("viol_data", tx_key(tx_ring_out), 32'h600D0001);
    tx_in = mk_tx(tx_none, 32'd0);
    cyc();
    chk("viol_err_pulse", 32'(err), 32'd0);
    run_tokens(8, n, dones);
    chk("viol_restart", tx_key(tx_ring_out), 32'h5A210100);

    // Retry exhaustion: three transmissions, then one err pulse.
    do_reset();
    starts = 0; errs = 0; err_t = 0; badseq = 0;
    ts = '{0, 0, 0, 0};
    req  = 1'b1;
    data = 32'h5555AAAA;
    cyc();
    req = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tx_in = (tx_ring_out.stype == tx_start) ? mk_tx(tx_none, 32'd0) : mk_tx(tx_start_empty, 32'd0);
      cyc();
      if (tx_ring_out.stype == tx_start) begin
        if (starts < 4) ts[starts] = t;
        starts++;
        if (tx_key(tx_ring_out) != 32'h5A210100) badseq++;
      end
      if (err) begin
        errs++;
        err_t = t;
      end
    end
    tx_in = mk_tx(tx_none, 32'd0);
    chk("exh_starts", 32'(starts), 32'd3);
    chk("exh_gap1", 32'((ts[1] - ts[0]) >= TMO), 32'd1);
    chk("exh_gap2", 32'((ts[2] - ts[1]) >= TMO), 32'd1);
    chk("exh_badseq", 32'(badseq), 32'd0);
    chk("exh_errs", 32'(errs), 32'd1);
    chk("exh_err_late", 32'(err_t > ts[2]), 32'd1);
    chk("exh_busy0", 32'(busy), 32'd0);
    send_report("exh_next", 32'h00000077, 16'h0100);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b0);
    chk("exh_next_done", 32'(done), 32'd1);

    // Sequence wrap from 0xFFFF.
    do_reset();
    frc        = '0;
    frc.seqnum = 16'hFFFF;
    force dut.r_q = frc;
    cyc();
    release dut.r_q;
    cyc();
    send_report("wrap", 32'h0F0F0F0F, 16'h0000);
    send_ack(TMPID, ackPacketType, 16'h0000, 1'b0);
    chk("wrap_done", 32'(done), 32'd1);
    send_report("wrap_next", 32'h0E0E0E0E, 16'h0100);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b0);
    chk("wrap_next_done", 32'(done), 32'd1);

    // Reset while waiting for the ack abandons the report silently.
    do_reset();
    send_report("mid", 32'h12121212, 16'h0100);
    tx_in = mk_tx(tx_start_empty, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_tx_none", 32'(tx_ring_out.stype), 32'(tx_none));
    chk("mid_busy0", 32'(busy), 32'd0);
    chk("mid_done0", 32'(done), 32'd0);
    chk("mid_err0", 32'(err), 32'd0);
    cyc();
    reset = 1'b0;
    tx_in = mk_tx(tx_none, 32'd0);
    dones = 0; errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) rx_in = mk_rx(rx_start, TMPID, ackPacketType, 16'h0100, 32'd0);
      else if (i == 1) rx_in = mk_rx(rx_end, 8'd0, 8'd0, 16'd0, 32'd0);
      else rx_in = mk_rx(rx_none, 8'd0, 8'd0, 16'd0, 32'd0);
      cyc();
      if (done) dones++;
      if (err) errs++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    chk("mid_no_err", 32'(errs), 32'd0);
    send_report("mid_new", 32'h34343434, 16'h0100);
    send_ack(TMPID, ackPacketType, 16'h0100, 1'b0);
    chk("mid_new_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tm_report.md
ETH_TM_REPORT -- requirements
Module: eth_tm_report

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: cycles to wait for ack/nack before retransmitting.
REQ-002 Parameter MAX_RETRY, default 7: retransmissions allowed before the report is abandoned.
REQ-003 Parameter RPT_PID, default TMPID: header pid used on sent and matched packets.
REQ-004 Port clk  in  1  single clock; all state on its rising edge.
REQ-005 Port reset  in  1  reset, asynchronous, active-high.
REQ-006 Port rx_pipe_in  in  eth_rx_pipe_data_type  received message stream (acks and nacks).
REQ-007 Port rx_pipe_out  out  eth_rx_pipe_data_type  rx_pipe_in delayed one cycle, unchanged.
REQ-008 Port tx_ring_in  in  eth_tx_ring_data_type  upstream tx ring slot.
REQ-009 Port tx_ring_out  out  eth_tx_ring_data_type  downstream tx ring slot, registered.
REQ-010 Port rpt_req  in  1  request to send one report; sampled only when busy=0.
REQ-011 Port rpt_data  in  32  report payload, latched when rpt_req is accepted.
REQ-012 Port busy  out  1  high from acceptance until done or err.
REQ-013 Port done  out  1  one-cycle pulse when a matching good ack is received.
REQ-014 Port err  out  1  one-cycle pulse when the retry limit is exceeded or the ring is violated.

Function
REQ-015 States SHALL be rp_idle, rp_wait_token, rp_send_data, rp_wait_ack, rp_check_ack.
REQ-016 rp_idle: rpt_req=1 latches rpt_data, sets tmpseq=seqnum+1 (16-bit wrap), clears the retry count, and moves to rp_wait_token.
REQ-017 rp_wait_token: on tx_ring_in.stype==tx_start_empty, tx_ring_out in the next cycle SHALL be tx_start with pid=RPT_PID, seqnum=ldsts_big_endian(tmpseq), ptype=rptPacketType; next state rp_send_data.
REQ-018 Any other tx_ring_in value in rp_wait_token SHALL be forwarded unchanged.
REQ-019 rp_send_data: tx_ring_out SHALL be tx_data with msg.data=latched payload, the timeout counter SHALL clear, and the next state SHALL be rp_wait_ack.
REQ-020 In rp_send_data, if tx_ring_in.stype!=tx_none, err SHALL pulse and the packet SHALL count as one failed attempt.
REQ-021 rp_wait_ack: rx_start with pid==RPT_PID, ptype in {ackPacketType, nackPacketType}, and byte-swapped seqnum==tmpseq SHALL move to rp_check_ack and record the ptype.
REQ-022 In rp_wait_ack, non-matching packets SHALL be ignored.
REQ-023 rp_check_ack: on rx_end with msg.data[0]==0 and a recorded ack, seqnum<=tmpseq, done SHALL pulse, and the next state SHALL be rp_idle.
REQ-024 On rx_end that is a nack or has msg.data[0]==1, the block SHALL retry.
REQ-025 Timeout: if the 16-bit counter reaches TIMEOUT_CYCLES-1 in rp_wait_ack or rp_check_ack, the block SHALL retry; the counter saturates and does not wrap.
REQ-026 Retry: retry count +1; if count<MAX_RETRY, go to rp_wait_token keeping the same tmpseq and payload; otherwise err pulses, seqnum is unchanged, and the next state is rp_idle.
REQ-027 A timeout and an rx_end in the same cycle SHALL resolve in favour of rx_end.
REQ-028 Latency: rpt_req accepted in cycle n puts the FSM in rp_wait_token in cycle n+1; a token in cycle m gives tx_start at m+1 and tx_data at m+2.
REQ-029 rx_pipe_out SHALL always equal rx_pipe_in of the prior cycle; acks are observed, not consumed.
REQ-030 tx_ring_out SHALL equal tx_ring_in of the prior cycle whenever the block is not driving the slot.

Reset
REQ-031 Reset SHALL force state=rp_idle, seqnum=0, tmpseq=0, retry count=0, timeout counter=0, and busy/done/err=0.
REQ-032 Reset SHALL force tx_ring_out.stype=tx_none and rx_pipe_out.stype=rx_none.
REQ-033 Reset mid-transfer SHALL abandon the report with no done or err pulse.

Structure
REQ-034 tx_data and rptPacketType SHALL be added to libeth.
REQ-035 The eth_tm_report_state_type enum SHALL live in libeth.
REQ-036 TIMEOUT and retry widths SHALL be constants in libeth.
REQ-037 Design style SHALL be a single module with a comb next-state block and one registered state struct; no sub-module.

Verification
REQ-038 Good ack: req with data 0xCAFEF00D, token at cycle 3 -> tx_start seq 0x0100 (seq 1 swapped) at 4, tx_data 0xCAFEF00D at 5; ack seq 1 with rx_end data[0]=0 -> done pulse, busy falls.
REQ-039 Nack then ack: first response nack seq 1 -> second tx_start with the same seq 0x0100 and the same payload; ack -> done; seqnum=1.
REQ-040 Timeout exhaustion with TIMEOUT_CYCLES=16, MAX_RETRY=2 and no responses -> 3 transmissions spaced by at least 16 cycles, then err pulse, and the next report uses seq 1 again.
REQ-041 CRC-bad ack (rx_end data[0]=1) -> retransmit; ack with the wrong seq or wrong pid is ignored until the timeout.
REQ-042 Seq wrap: seqnum preset to 0xFFFF via 65535 completed reports (or forced), then the next report -> tmpseq 0x0000 and a correct ack match.
REQ-043 Reset asserted while in rp_wait_ack -> tx_ring_out tx_none, busy 0, and no done/err; a new req is accepted with seq 1.
